// File: rtl/mm_issue_queue.sv
// rtl/mm_issue_queue.sv - job FIFO and issue controller feeding the pipelined Montgomery multiplier.
// Buffers (a, b, tag) jobs, paces en_mm pulses, tracks in-flight jobs and holds the modulus set.
module mm_issue_queue #(
  parameter int M_SIZE    = 3072,
  parameter int RADIX     = 72,
  parameter int SIZE_LOG  = 6,
  parameter int Q_DEPTH   = 4,
  parameter int Q_AW      = 2,
  parameter int MAX_OUT   = 8,
  parameter int ISSUE_GAP = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [M_SIZE-1:0]           req_a,
  input  logic [M_SIZE-1:0]           req_b,
  input  logic [3:0]                  req_info,
  input  logic                        cfg_load,
  input  logic [M_SIZE-1:0]           cfg_m,
  input  logic [M_SIZE+1:0]           cfg_m_n,
  input  logic [RADIX+SIZE_LOG+1:0]   cfg_m_prime,
  output logic                        cfg_err,
  output logic                        en_mm,
  output logic [M_SIZE-1:0]           a,
  output logic [M_SIZE-1:0]           b,
  output logic [M_SIZE-1:0]           m,
  output logic [M_SIZE+1:0]           m_n,
  output logic [RADIX+SIZE_LOG+1:0]   m_prime,
  output logic [3:0]                  mm_info_in,
  input  logic                        mm_full,
  input  logic                        mm_done,
  input  logic [3:0]                  mm_info_out,
  output logic                        done_valid,
  output logic [3:0]                  done_info,
  output logic [3:0]                  outstanding,
  output logic [Q_AW:0]               q_count,
  output logic                        idle
);

  localparam int MPW = RADIX + SIZE_LOG + 2;
  localparam logic [Q_AW:0] DEPTH_C  = Q_DEPTH[Q_AW:0];
  localparam logic [3:0]    MAX_C    = MAX_OUT[3:0];
  localparam logic [7:0]    GAP_LOAD = 8'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  logic [M_SIZE-1:0] mem_a_q [Q_DEPTH];
  logic [M_SIZE-1:0] mem_b_q [Q_DEPTH];
  logic [3:0]        mem_i_q [Q_DEPTH];

  state_t            state_q, state_d;
  logic [Q_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Q_AW:0]     cnt_q, cnt_d;
  logic [7:0]        gap_q, gap_d;
  logic [3:0]        out_q, out_d;
  logic [M_SIZE-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [M_SIZE+1:0] m_n_q, m_n_d;
  logic [MPW-1:0]    m_prime_q, m_prime_d;
  logic [3:0]        info_q, info_d, done_info_q, done_info_d;
  logic              done_valid_q, done_valid_d, cfg_err_q, cfg_err_d;

  logic push, fire, idle_w, inc, dec;

  assign req_ready = (cnt_q != DEPTH_C);
  assign push      = req_valid && req_ready;
  assign idle_w    = (cnt_q == '0) && (out_q == '0) && (state_q == S_IDLE);
  // Only this cycle's mm_full is looked at; the decision registers into ISSUE.
  assign fire      = (state_q == S_IDLE) && (cnt_q != '0) && !mm_full && (out_q < MAX_C);
  assign inc       = (state_q == S_ISSUE);
  assign dec       = mm_done && (out_q != '0);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    out_d        = out_q;
    a_d          = a_q;
    b_d          = b_q;
    info_d       = info_q;
    m_d          = m_q;
    m_n_d        = m_n_q;
    m_prime_d    = m_prime_q;
    cfg_err_d    = cfg_err_q;
    done_valid_d = mm_done;
    done_info_d  = mm_done ? mm_info_out : done_info_q;

    case (state_q)
      S_IDLE: begin
        if (fire) begin
          state_d  = S_ISSUE;
          a_d      = mem_a_q[rd_ptr_q];
          b_d      = mem_b_q[rd_ptr_q];
          info_d   = mem_i_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + Q_AW'(1);
        end
      end
      S_ISSUE: begin
        if (ISSUE_GAP == 1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + Q_AW'(1);
    case ({push, fire})
      2'b10:   cnt_d = cnt_q + (Q_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (Q_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({inc, dec})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    // The modulus set may only move when nothing is queued or in flight.
    if (cfg_load) begin
      if (idle_w) begin
        m_d       = cfg_m;
        m_n_d     = cfg_m_n;
        m_prime_d = cfg_m_prime;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      out_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      info_q       <= '0;
      m_q          <= '0;
      m_n_q        <= '0;
      m_prime_q    <= '0;
      cfg_err_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_info_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      out_q        <= out_d;
      a_q          <= a_d;
      b_q          <= b_d;
      info_q       <= info_d;
      m_q          <= m_d;
      m_n_q        <= m_n_d;
      m_prime_q    <= m_prime_d;
      cfg_err_q    <= cfg_err_d;
      done_valid_q <= done_valid_d;
      done_info_q  <= done_info_d;
    end
  end

  // Payload storage needs no reset; the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= req_a;
      mem_b_q[wr_ptr_q] <= req_b;
      mem_i_q[wr_ptr_q] <= req_info;
    end
  end

  assign en_mm       = (state_q == S_ISSUE);
  assign a           = a_q;
  assign b           = b_q;
  assign mm_info_in  = info_q;
  assign m           = m_q;
  assign m_n         = m_n_q;
  assign m_prime     = m_prime_q;
  assign cfg_err     = cfg_err_q;
  assign done_valid  = done_valid_q;
  assign done_info   = done_info_q;
  assign outstanding = out_q;
  assign q_count     = cnt_q;
  assign idle        = idle_w;

endmodule

// File: tb/tb_mm_issue_queue.sv
// tb/tb_mm_issue_queue.sv - self-checking bench for mm_issue_queue.
// Rule-level model updated on rising edges, compared against the DUT on falling edges.
module tb_mm_issue_queue;

  localparam int MS  = 3072;
  localparam int MPW = 80;
  localparam int GAP = 4;
  localparam int MAXO = 8;
  localparam int QD  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready;
  logic [MS-1:0]   req_a, req_b;
  logic [3:0]      req_info;
  logic            cfg_load, cfg_err;
  logic [MS-1:0]   cfg_m;
  logic [MS+1:0]   cfg_m_n;
  logic [MPW-1:0]  cfg_m_prime;
  logic            en_mm;
  logic [MS-1:0]   a, b, m;
  logic [MS+1:0]   m_n;
  logic [MPW-1:0]  m_prime;
  logic [3:0]      mm_info_in, mm_info_out, done_info, outstanding;
  logic            mm_full, mm_done, done_valid, idle;
  logic [2:0]      q_count;

  mm_issue_queue dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_info(req_info),
    .cfg_load(cfg_load), .cfg_m(cfg_m), .cfg_m_n(cfg_m_n), .cfg_m_prime(cfg_m_prime),
    .cfg_err(cfg_err), .en_mm(en_mm), .a(a), .b(b),
    .m(m), .m_n(m_n), .m_prime(m_prime), .mm_info_in(mm_info_in),
    .mm_full(mm_full), .mm_done(mm_done), .mm_info_out(mm_info_out),
    .done_valid(done_valid), .done_info(done_info),
    .outstanding(outstanding), .q_count(q_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk(nm, act === exp, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Model: pending jobs as a queue; issue timing from the spacing rule.
  typedef struct {
    logic [MS-1:0] a;
    logic [MS-1:0] b;
    logic [3:0]    i;
  } job_t;

  job_t           mq[$];
  job_t           mj;
  int             m_out = 0;
  bit             m_en = 0;
  int             m_last = -1000;
  int             cyc = 0;
  logic [MS-1:0]  m_a = '0, m_b = '0, m_m = '0;
  logic [MS+1:0]  m_mn = '0;
  logic [MPW-1:0] m_mp = '0;
  logic [3:0]     m_info = '0, m_dinfo = '0;
  bit             m_dv = 0, m_err = 0;
  bit             st_idle, idle_m, fire, push;
  int             nout;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_out = 0; m_en = 0; m_last = -1000;
      m_a = '0; m_b = '0; m_m = '0; m_mn = '0; m_mp = '0;
      m_info = '0; m_dinfo = '0; m_dv = 0; m_err = 0;
    end else begin
      st_idle = !m_en && (cyc >= m_last + GAP);
      idle_m  = (mq.size() == 0) && (m_out == 0) && st_idle;
      push    = req_valid && (mq.size() != QD);
      fire    = st_idle && (mq.size() > 0) && !mm_full && (m_out < MAXO);
      nout    = m_out + (m_en ? 1 : 0) - ((mm_done && m_out > 0) ? 1 : 0);
      if (cfg_load) begin
        if (idle_m) begin m_m = cfg_m; m_mn = cfg_m_n; m_mp = cfg_m_prime; end
        else m_err = 1;
      end
      m_dv = mm_done;
      if (mm_done) m_dinfo = mm_info_out;
      if (m_en) m_last = cyc;
      if (fire) begin
        mj = mq.pop_front();
        m_a = mj.a; m_b = mj.b; m_info = mj.i;
      end
      if (push) begin
        mj.a = req_a; mj.b = req_b; mj.i = req_info;
        mq.push_back(mj);
      end
      m_en  = fire;
      m_out = nout;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q_count", q_count == 3'(mq.size()), 64'(q_count), 64'(mq.size()));
      chk("req_ready", req_ready === (mq.size() != QD), 64'(req_ready), 64'(mq.size() != QD));
      chk("en_mm", en_mm === m_en, 64'(en_mm), 64'(m_en));
      chk("outstanding", outstanding == 4'(m_out), 64'(outstanding), 64'(m_out));
      chk("idle", idle === ((mq.size() == 0) && (m_out == 0) && !m_en && (cyc >= m_last + GAP)),
          64'(idle), 64'((mq.size() == 0) && (m_out == 0) && !m_en && (cyc >= m_last + GAP)));
      chk("done_valid", done_valid === m_dv, 64'(done_valid), 64'(m_dv));
      chk("done_info", done_info === m_dinfo, 64'(done_info), 64'(m_dinfo));
      chk("cfg_err", cfg_err === m_err, 64'(cfg_err), 64'(m_err));
      chk("a", a === m_a, a[63:0], m_a[63:0]);
      chk("b", b === m_b, b[63:0], m_b[63:0]);
      chk("mm_info_in", mm_info_in === m_info, 64'(mm_info_in), 64'(m_info));
      chk("m", m === m_m, m[63:0], m_m[63:0]);
      chk("m_n", m_n === m_mn, m_n[63:0], m_mn[63:0]);
      chk("m_prime", m_prime === m_mp, m_prime[63:0], m_mp[63:0]);
    end
  end

  task automatic set_job(input int k);
    req_a = MS'(100 + k); req_b = MS'(k); req_info = 4'(k);
  endtask

  int issue_t[$];
  int issue_tag[$];
  int sent, ens, seen;
  bit acc;

  initial begin
    rst_n = 0; req_valid = 0; req_a = '0; req_b = '0; req_info = '0;
    cfg_load = 0; cfg_m = '0; cfg_m_n = '0; cfg_m_prime = '0;
    mm_full = 0; mm_done = 0; mm_info_out = '0;
    step();
    chk_en = 1;
    lit("rst_ready", 64'(req_ready), 64'd1);
    lit("rst_idle", 64'(idle), 64'd1);
    lit("rst_en", 64'(en_mm), 64'd0);
    step(); step();
    rst_n = 1;

    // Modulus load when idle.
    cfg_load = 1; cfg_m = MS'(13); cfg_m_n = '0; cfg_m_prime = MPW'(1);
    step();
    cfg_load = 0;
    lit("cfg_m_loaded", m[63:0], 64'hD);
    lit("cfg_mp_loaded", m_prime[63:0], 64'h1);
    lit("cfg_idle", 64'(idle), 64'd1);
    lit("cfg_err0", 64'(cfg_err), 64'd0);

    // Single job: two-cycle latency, completion.
    req_valid = 1; req_a = MS'(5); req_b = MS'(1); req_info = 4'h4;
    step();
    req_valid = 0;
    lit("lat_en_c1", 64'(en_mm), 64'd0);
    step();
    lit("lat_en_c2", 64'(en_mm), 64'd1);
    lit("lat_a", a[63:0], 64'h5);
    lit("lat_b", b[63:0], 64'h1);
    lit("lat_tag", 64'(mm_info_in), 64'h4);
    step();
    lit("out_one", 64'(outstanding), 64'd1);
    mm_done = 1; mm_info_out = 4'h4;
    step();
    mm_done = 0;
    lit("done_v", 64'(done_valid), 64'd1);
    lit("done_tag", 64'(done_info), 64'h4);
    lit("out_zero", 64'(outstanding), 64'd0);
    repeat (3) step();
    lit("idle_after", 64'(idle), 64'd1);

    // Five jobs into a four-deep queue while the multiplier is full.
    mm_full = 1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1; set_job(8 + k);
      step();
    end
    lit("full_ready", 64'(req_ready), 64'd0);
    lit("full_count", 64'(q_count), 64'd4);
    lit("full_no_en", 64'(en_mm), 64'd0);
    set_job(12);
    mm_full = 0;
    for (int t = 0; t < 40; t++) begin
      acc = req_valid && req_ready;
      step();
      if (acc) req_valid = 0;
      if (en_mm) begin issue_t.push_back(t); issue_tag.push_back(int'(mm_info_in)); end
    end
    req_valid = 0;
    lit("burst_issues", 64'(issue_t.size()), 64'd5);
    for (int k = 0; k < issue_tag.size(); k++) lit("burst_order", 64'(issue_tag[k]), 64'(8 + k));
    for (int k = 1; k < issue_t.size(); k++) lit("burst_gap", 64'(issue_t[k] - issue_t[k-1]), 64'd5);
    for (int k = 0; k < 5; k++) begin
      mm_done = 1; mm_info_out = 4'(12 - k);
      step();
    end
    mm_done = 0;
    lit("burst_drain", 64'(outstanding), 64'd0);
    lit("burst_last_tag", 64'(done_info), 64'h8);

    // mm_full holds back issue; release gives en_mm one cycle later.
    mm_full = 1;
    for (int k = 1; k <= 2; k++) begin
      req_valid = 1; set_job(k);
      step();
    end
    req_valid = 0;
    seen = 0;
    repeat (6) begin step(); if (en_mm) seen++; end
    lit("hold_no_en", 64'(seen), 64'd0);
    lit("hold_count", 64'(q_count), 64'd2);
    mm_full = 0;
    step();
    lit("release_en", 64'(en_mm), 64'd1);
    lit("release_tag", 64'(mm_info_in), 64'd1);
    repeat (8) step();
    lit("hold_out", 64'(outstanding), 64'd2);
    mm_done = 1; mm_info_out = 4'd2; step();
    mm_info_out = 4'd1; step();
    mm_done = 0;

    // Ten jobs, no completions: issue stalls at MAX_OUT.
    sent = 0; ens = 0;
    req_valid = 1; set_job(0);
    for (int t = 0; t < 80; t++) begin
      acc = req_valid && req_ready;
      step();
      if (acc) begin
        sent++;
        if (sent < 10) set_job(sent); else req_valid = 0;
      end
      if (en_mm) ens++;
    end
    req_valid = 0;
    lit("max_sent", 64'(sent), 64'd10);
    lit("max_issues", 64'(ens), 64'd8);
    lit("max_out", 64'(outstanding), 64'd8);
    lit("max_queued", 64'(q_count), 64'd2);
    mm_done = 1; mm_info_out = 4'd0;
    step();
    mm_done = 0;
    lit("max_out_dec", 64'(outstanding), 64'd7);
    lit("max_decide", 64'(en_mm), 64'd0);
    step();
    lit("max_resume_en", 64'(en_mm), 64'd1);
    mm_done = 1; mm_info_out = 4'd1;
    step();
    mm_done = 0;
    lit("issue_and_done", 64'(outstanding), 64'd7);
    repeat (6) step();
    lit("max_refill", 64'(outstanding), 64'd8);
    lit("max_empty", 64'(q_count), 64'd0);

    // Config rejected while busy.
    cfg_load = 1; cfg_m = MS'(99);
    step();
    cfg_load = 0;
    lit("busy_m", m[63:0], 64'hD);
    lit("busy_err", 64'(cfg_err), 64'd1);

    // Reset in the middle of queued and in-flight work.
    mm_full = 1;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1; set_job(3 + k);
      step();
    end
    req_valid = 0;
    lit("pre_rst_count", 64'(q_count), 64'd2);
    rst_n = 0;
    step();
    lit("rst_count", 64'(q_count), 64'd0);
    lit("rst_out", 64'(outstanding), 64'd0);
    lit("rst_en_mid", 64'(en_mm), 64'd0);
    lit("rst_err", 64'(cfg_err), 64'd0);
    lit("rst_idle_mid", 64'(idle), 64'd1);
    rst_n = 1; mm_full = 0;
    repeat (4) step();
    lit("post_rst_en", 64'(en_mm), 64'd0);
    lit("post_rst_idle", 64'(idle), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
